// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, RGB565 colours and counter types.
package vga_pkg;

    localparam int CNT_W       = 10;
    localparam int CNT_MAX_VAL = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [15:0]      rgb565_t;

    // 640x480@60, 25 MHz pixel clock
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BACK      = 48;
    localparam int VGA_H_VALID     = 640;
    localparam int VGA_H_FRONT     = 16;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BACK      = 33;
    localparam int VGA_V_VALID     = 480;
    localparam int VGA_V_FRONT     = 10;
    localparam int VGA_PIX_LATENCY = 1;

    // Coordinate value presented when no pixel is being requested
    localparam cnt_t PIX_NONE = 10'h3FF;

    localparam rgb565_t RGB565_BLACK = 16'h0000;
    localparam rgb565_t RGB565_WHITE = 16'hFFFF;
    localparam rgb565_t RGB565_RED   = 16'hF800;
    localparam rgb565_t RGB565_GREEN = 16'h07E0;
    localparam rgb565_t RGB565_BLUE  = 16'h001F;

    function automatic int timing_total(input int sync_w, input int back_w,
                                        input int valid_w, input int front_w);
        return sync_w + back_w + valid_w + front_w;
    endfunction

    localparam int VGA_H_TOTAL = timing_total(VGA_H_SYNC, VGA_H_BACK, VGA_H_VALID, VGA_H_FRONT);
    localparam int VGA_V_TOTAL = timing_total(VGA_V_SYNC, VGA_V_BACK, VGA_V_VALID, VGA_V_FRONT);

endpackage

// File: rtl/vga_sync_counter.sv
// Wrap counter 0..TOTAL-1 with enable and carry-out on the wrapping step.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             carry_o
);

    localparam cnt_t CNT_LAST = cnt_t'(TOTAL - 1);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Advance when enabled, wrapping to zero after the last value
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign carry_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: sync pulses, active window, pixel request with
// look-ahead of PIX_LATENCY clocks, and colour gating to the DAC.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int H_VALID     = VGA_H_VALID,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int V_VALID     = VGA_V_VALID,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int PIX_LATENCY = VGA_PIX_LATENCY
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_data_req,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL   = timing_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
    localparam int V_TOTAL   = timing_total(V_SYNC, V_BACK, V_VALID, V_FRONT);
    localparam int H_ACT_BEG = H_SYNC + H_BACK;
    localparam int V_ACT_BEG = V_SYNC + V_BACK;

    if (H_TOTAL > CNT_MAX_VAL || V_TOTAL > CNT_MAX_VAL) begin : g_bad_total
        $error("vga_timing_ctrl: line or frame total does not fit a 10-bit counter");
    end
    if (PIX_LATENCY < 1 || PIX_LATENCY > 4 || PIX_LATENCY > H_ACT_BEG) begin : g_bad_latency
        $error("vga_timing_ctrl: PIX_LATENCY must be 1..4 and not exceed sync+back porch");
    end

    localparam cnt_t H_SYNC_C    = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_C    = cnt_t'(V_SYNC);
    localparam cnt_t H_ACT_BEG_C = cnt_t'(H_ACT_BEG);
    localparam cnt_t H_ACT_END_C = cnt_t'(H_ACT_BEG + H_VALID);
    localparam cnt_t H_REQ_BEG_C = cnt_t'(H_ACT_BEG - PIX_LATENCY);
    localparam cnt_t H_REQ_END_C = cnt_t'(H_ACT_BEG + H_VALID - PIX_LATENCY);
    localparam cnt_t V_ACT_BEG_C = cnt_t'(V_ACT_BEG);
    localparam cnt_t V_ACT_END_C = cnt_t'(V_ACT_BEG + V_VALID);

    cnt_t cnt_h;
    cnt_t cnt_v;
    logic h_carry;
    logic v_carry;
    logic h_act;
    logic h_req;
    logic v_act;
    logic frame_start_q;
    logic frame_start_d;

    vga_sync_counter #(.TOTAL(H_TOTAL)) u_cnt_h (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (1'b1),
        .cnt_o     (cnt_h),
        .carry_o   (h_carry)
    );

    vga_sync_counter #(.TOTAL(V_TOTAL)) u_cnt_v (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (h_carry),
        .cnt_o     (cnt_v),
        .carry_o   (v_carry)
    );

    // Window decode straight from the counter registers
    always_comb begin
        h_act = (cnt_h >= H_ACT_BEG_C) && (cnt_h < H_ACT_END_C);
        h_req = (cnt_h >= H_REQ_BEG_C) && (cnt_h < H_REQ_END_C);
        v_act = (cnt_v >= V_ACT_BEG_C) && (cnt_v < V_ACT_END_C);
    end

    assign hsync        = (cnt_h < H_SYNC_C);
    assign vsync        = (cnt_v < V_SYNC_C);
    assign rgb_valid    = h_act && v_act;
    assign pix_data_req = h_req && v_act;
    assign pix_x        = pix_data_req ? cnt_h - H_REQ_BEG_C : PIX_NONE;
    assign pix_y        = pix_data_req ? cnt_v - V_ACT_BEG_C : PIX_NONE;
    assign rgb          = rgb_valid ? pix_data : RGB565_BLACK;

    // The wrap of both counters marks the next cycle as the frame origin;
    // counters sitting at 0 right after reset release never produce a carry.
    assign frame_start_d = v_carry;

    // Frame origin pulse register
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: two default-timing instances (latency 1 and 2) checked on line 35,
// plus a reduced-timing instance for multi-frame, mid-frame reset and
// end-of-active-window checks.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    localparam int HT      = 800;
    localparam int S_HS    = 8;
    localparam int S_HB    = 6;
    localparam int S_HV    = 16;
    localparam int S_HF    = 4;
    localparam int S_VS    = 2;
    localparam int S_VB    = 3;
    localparam int S_VV    = 6;
    localparam int S_VF    = 2;
    localparam int S_HT    = 34;
    localparam int S_VT    = 13;
    localparam int S_FRAME = 442;
    localparam int RST_AT  = 2 * S_FRAME + 7 * S_HT + 20;
    localparam int A_STOP  = 36 * HT + 10;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic rst_n_a = 1'b0;
    logic rst_n_s = 1'b0;

    logic [15:0] pix_data_a, pix_data_b, pix_pipe_b, pix_data_s;
    logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b, pix_x_s, pix_y_s;
    logic        req_a, req_b, req_s;
    logic        hsync_a, hsync_b, hsync_s, vsync_a, vsync_b, vsync_s;
    logic        rv_a, rv_b, rv_s, fs_a, fs_b, fs_s;
    logic [15:0] rgb_a, rgb_b, rgb_s;

    vga_timing_ctrl u_dut_a (
        .vga_clk(vga_clk), .sys_rst_n(rst_n_a), .pix_data(pix_data_a),
        .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_data_req(req_a),
        .hsync(hsync_a), .vsync(vsync_a), .rgb_valid(rv_a), .rgb(rgb_a),
        .frame_start(fs_a)
    );

    vga_timing_ctrl #(.PIX_LATENCY(2)) u_dut_b (
        .vga_clk(vga_clk), .sys_rst_n(rst_n_a), .pix_data(pix_data_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_data_req(req_b),
        .hsync(hsync_b), .vsync(vsync_b), .rgb_valid(rv_b), .rgb(rgb_b),
        .frame_start(fs_b)
    );

    vga_timing_ctrl #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_FRONT(S_VF),
        .PIX_LATENCY(1)
    ) u_dut_s (
        .vga_clk(vga_clk), .sys_rst_n(rst_n_s), .pix_data(pix_data_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_data_req(req_s),
        .hsync(hsync_s), .vsync(vsync_s), .rgb_valid(rv_s), .rgb(rgb_s),
        .frame_start(fs_s)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_rst(input string name, input logic hs, input logic vs, input logic rv,
                           input logic rq, input logic [9:0] x, input logic [9:0] y,
                           input logic [15:0] c, input logic fs);
        chk({name, "_hsync"}, hs, 1);
        chk({name, "_vsync"}, vs, 1);
        chk({name, "_rgb_valid"}, rv, 0);
        chk({name, "_req"}, rq, 0);
        chk({name, "_pix_x"}, x, 10'h3FF);
        chk({name, "_pix_y"}, y, 10'h3FF);
        chk({name, "_rgb"}, c, 0);
        chk({name, "_frame_start"}, fs, 0);
    endtask

    function automatic logic [15:0] colour(input logic [9:0] x, input logic [9:0] y);
        return {y[5:0], x} ^ 16'h5A5A;
    endfunction

    // Picture stage models: 1-clock for A and S, 2-clock for B
    always @(posedge vga_clk) begin
        pix_data_a <= colour(pix_x_a, pix_y_a);
        pix_pipe_b <= colour(pix_x_b, pix_y_b);
        pix_data_b <= pix_pipe_b;
        pix_data_s <= colour(pix_x_s, pix_y_s);
    end

    // Reference position: clocks since reset release
    longint cyc_a, cyc_s;
    always @(posedge vga_clk or negedge rst_n_a)
        if (!rst_n_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge vga_clk or negedge rst_n_s)
        if (!rst_n_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;

    logic [19:0] exp_req_q[$];
    logic [15:0] exp_rgb_q[$];

    int     h_a, v_a, h_s, v_s;
    logic   hs_prev_a, vs_prev_a, hs_prev_s, vs_prev_s;
    longint hs_rise_a, hs_rise_s, vs_rise_s;
    int     hs_rises_a = 0, vs_falls_a = 0, fs_cnt_a = 0, fs_cnt_b = 0;
    int     fs_pre = 0;
    longint fs_after = -1;
    bit     s_phase = 0;
    logic [19:0] e_req;
    logic [15:0] e_rgb;

    // Monitor: default-timing instances
    always @(negedge vga_clk) begin
        if (!rst_n_a) begin
            hs_prev_a = 1'b1;
            vs_prev_a = 1'b1;
            hs_rise_a = 0;
        end else begin
            h_a = int'(cyc_a % HT);
            v_a = int'(cyc_a / HT);
            if (req_a) begin
                if (exp_req_q.size() == 0) chk("a_req_unexpected", {pix_x_a, pix_y_a}, 20'hFFFFF);
                else begin
                    e_req = exp_req_q.pop_front();
                    chk("a_req_xy", {pix_x_a, pix_y_a}, e_req);
                end
            end
            if (rv_a) begin
                if (exp_rgb_q.size() == 0) chk("a_rgb_unexpected", rgb_a, 16'h0);
                else begin
                    e_rgb = exp_rgb_q.pop_front();
                    chk("a_rgb", rgb_a, e_rgb);
                end
            end
            if (hsync_a && !hs_prev_a) begin
                chk("a_hsync_period", cyc_a - hs_rise_a, HT);
                hs_rise_a = cyc_a;
                hs_rises_a++;
            end
            if (!hsync_a && hs_prev_a) chk("a_hsync_high", cyc_a - hs_rise_a, 96);
            if (!vsync_a && vs_prev_a) begin
                chk("a_vsync_high", cyc_a, 1600);
                vs_falls_a++;
            end
            hs_prev_a = hsync_a;
            vs_prev_a = vsync_a;
            if (fs_a) fs_cnt_a++;
            if (fs_b) fs_cnt_b++;
            if (v_a == 35) begin
                case (h_a)
                    141: chk("b_req_141", req_b, 0);
                    142: begin
                        chk("a_req_142", req_a, 0);
                        chk("b_req_142", req_b, 1);
                        chk("b_x_142", pix_x_b, 0);
                        chk("b_y_142", pix_y_b, 0);
                    end
                    143: begin
                        chk("a_req_143", req_a, 1);
                        chk("a_x_143", pix_x_a, 0);
                        chk("a_y_143", pix_y_a, 0);
                        chk("a_rv_143", rv_a, 0);
                        chk("a_rgb_143", rgb_a, 0);
                        chk("b_rv_143", rv_b, 0);
                    end
                    144: begin
                        chk("a_rv_144", rv_a, 1);
                        chk("b_rv_144", rv_b, 1);
                        chk("b_rgb_144", rgb_b, colour(10'd0, 10'd0));
                    end
                    781: chk("b_x_781", pix_x_b, 639);
                    782: begin
                        chk("a_req_782", req_a, 1);
                        chk("a_x_782", pix_x_a, 639);
                        chk("b_req_782", req_b, 0);
                        chk("b_y_782", pix_y_b, 10'h3FF);
                    end
                    783: begin
                        chk("a_req_783", req_a, 0);
                        chk("a_rv_783", rv_a, 1);
                        chk("b_rv_783", rv_b, 1);
                        chk("b_rgb_783", rgb_b, colour(10'd639, 10'd0));
                    end
                    784: begin
                        chk("a_rv_784", rv_a, 0);
                        chk("a_rgb_784", rgb_a, 0);
                        chk("b_rv_784", rv_b, 0);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: reduced-timing instance
    always @(negedge vga_clk) begin
        if (!rst_n_s) begin
            hs_prev_s = 1'b1;
            vs_prev_s = 1'b1;
            hs_rise_s = 0;
            vs_rise_s = 0;
        end else begin
            h_s = int'(cyc_s % S_HT);
            v_s = int'((cyc_s / S_HT) % S_VT);
            if (hsync_s && !hs_prev_s) begin
                chk("s_hsync_period", cyc_s - hs_rise_s, S_HT);
                hs_rise_s = cyc_s;
            end
            if (!hsync_s && hs_prev_s) chk("s_hsync_high", cyc_s - hs_rise_s, S_HS);
            if (vsync_s && !vs_prev_s) begin
                chk("s_vsync_period", cyc_s - vs_rise_s, S_FRAME);
                vs_rise_s = cyc_s;
            end
            if (!vsync_s && vs_prev_s) chk("s_vsync_high", cyc_s - vs_rise_s, S_VS * S_HT);
            hs_prev_s = hsync_s;
            vs_prev_s = vsync_s;
            if (fs_s) begin
                chk("s_fs_at_release", cyc_s == 0, 0);
                chk("s_fs_position", cyc_s % S_FRAME, 0);
                if (!s_phase) fs_pre++;
                else if (fs_after < 0) fs_after = cyc_s;
            end
            if (v_s == S_VS + S_VB + S_VV - 1 && h_s == S_HS + S_HB - 1) begin
                chk("s_last_line_req", req_s, 1);
                chk("s_last_line_x", pix_x_s, 0);
                chk("s_last_line_y", pix_y_s, S_VV - 1);
            end
            if (v_s == S_VS + S_VB + S_VV) begin
                chk("s_after_req", req_s, 0);
                chk("s_after_y", pix_y_s, 10'h3FF);
                chk("s_after_rv", rv_s, 0);
            end
        end
    end

    // Stimulus
    initial begin
        for (int x = 0; x < 640; x++) begin
            exp_req_q.push_back({10'(x), 10'd0});
            exp_rgb_q.push_back(colour(10'(x), 10'd0));
        end

        repeat (3) @(negedge vga_clk);
        chk_rst("a_rst", hsync_a, vsync_a, rv_a, req_a, pix_x_a, pix_y_a, rgb_a, fs_a);
        chk_rst("b_rst", hsync_b, vsync_b, rv_b, req_b, pix_x_b, pix_y_b, rgb_b, fs_b);
        chk_rst("s_rst", hsync_s, vsync_s, rv_s, req_s, pix_x_s, pix_y_s, rgb_s, fs_s);
        rst_n_a = 1'b1;
        rst_n_s = 1'b1;

        for (int i = 0; i < 5000 && cyc_s != RST_AT; i++) @(negedge vga_clk);
        chk("s_reach_reset_point", cyc_s, RST_AT);
        chk("s_active_before_reset", rv_s, 1);
        rst_n_s = 1'b0;
        #1;
        chk_rst("s_midrst", hsync_s, vsync_s, rv_s, req_s, pix_x_s, pix_y_s, rgb_s, fs_s);
        @(negedge vga_clk);
        chk_rst("s_midrst_hold", hsync_s, vsync_s, rv_s, req_s, pix_x_s, pix_y_s, rgb_s, fs_s);
        @(negedge vga_clk);
        s_phase = 1'b1;
        rst_n_s = 1'b1;

        for (int i = 0; i < 40000 && cyc_a < A_STOP; i++) @(negedge vga_clk);
        chk("a_reach_stop", cyc_a >= A_STOP, 1);

        chk("a_req_queue_drained", exp_req_q.size(), 0);
        chk("a_rgb_queue_drained", exp_rgb_q.size(), 0);
        chk("a_hsync_rises", hs_rises_a, 36);
        chk("a_vsync_falls", vs_falls_a, 1);
        chk("a_no_frame_start", fs_cnt_a, 0);
        chk("b_no_frame_start", fs_cnt_b, 0);
        chk("s_frames_before_reset", fs_pre, 2);
        chk("s_first_fs_after_reset", fs_after, S_FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
